counter_sequencer: RTL and testbench

- Command-side driver for the 4-bit up/down counter.
- Accepts a target value over a valid/ready request, then drives the counter's `u` (direction) and `SS` (step enable) inputs one step at a time until the counter's `cnt` equals the target.
- Reports completion or timeout with single-cycle pulses.
- Sits between control logic and the counter instance; it closes the loop by observing `cnt`.

---
 rtl/counter_sequencer.sv | 77 +++++++
 tb/tb_counter_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: steps an external up/down counter to a requested target; COUNTER_SEQ_WRAP_EN selects shortest modular path
module counter_sequencer #(
    parameter int WIDTH     = 4,
    parameter int MAX_STEPS = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] cnt,
    output logic             u,
    output logic             SS,
    output logic             busy,
    output logic             done,
    output logic             timeout
);
    localparam int CW = $clog2(MAX_STEPS + 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHECK  = 3'd1;
    localparam logic [2:0] STEP   = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] TOUT   = 3'd5;
    logic [2:0]       state;
    logic [2:0]       next;
    logic [WIDTH-1:0] target;
    logic [CW-1:0]    steps;
    logic             dir;
`ifdef COUNTER_SEQ_WRAP_EN
    logic [WIDTH-1:0] d_up;
    assign d_up = target - cnt;
    assign dir  = d_up <= WIDTH'(1 << (WIDTH - 1));
`else
    assign dir = target > cnt;
`endif
    // next-state selection; req_ready is high exactly in IDLE so req_valid alone accepts there
    always_comb begin
        next = IDLE;
        case (state)
            IDLE:    next = req_valid ? CHECK : IDLE;
            CHECK:   next = (cnt == target) ? DONE : (steps == CW'(MAX_STEPS)) ? TOUT : STEP;
            STEP:    next = SETTLE;
            SETTLE:  next = CHECK;
            default: next = IDLE;
        endcase
    end
    // all outputs are registered from the next state so each pulse lines up with its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            target    <= '0;
            steps     <= '0;
            u         <= 1'b0;
            SS        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= next;
            req_ready <= next == IDLE;
            busy      <= next != IDLE;
            SS        <= next == STEP;
            done      <= next == DONE;
            timeout   <= next == TOUT;
            if (state == IDLE && req_valid) begin
                target <= req_target;
                steps  <= '0;
            end
            if (state == CHECK && next == STEP) begin
                u     <= dir;
                steps <= steps + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: randomized scoreboard bench with a behavioural counter and path model
module tb_counter_sequencer;
    localparam int W  = 4;
    localparam int M  = 1 << W;
    localparam int TM = 4;

    typedef struct {
        int steps;
        int ups;
        int cycles;
        int fin;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_target = 4'd0;
    logic       req_ready, u, SS, busy, done, timeout;
    logic [3:0] cnt = 4'd0;
    logic       load_en = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic       t_valid = 1'b0;
    logic [3:0] t_target = 4'd0;
    logic [3:0] stuck = 4'd0;
    logic       t_ready, t_u, t_ss, t_busy, t_done, t_tout;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    bit active = 0;
    bit post = 0;
    bit prev = 0;
    int cyc, nss, nup;

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(W), .MAX_STEPS(20)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_target(req_target), .cnt(cnt), .u(u), .SS(SS), .busy(busy),
        .done(done), .timeout(timeout)
    );

    counter_sequencer #(.WIDTH(W), .MAX_STEPS(TM)) dut_t (
        .clk(clk), .rst_n(rst_n), .req_valid(t_valid), .req_ready(t_ready),
        .req_target(t_target), .cnt(stuck), .u(t_u), .SS(t_ss), .busy(t_busy),
        .done(t_done), .timeout(t_tout)
    );

    // behavioural counter driven by the sequencer; untouched by rst_n
    always @(posedge clk)
        if (load_en) cnt <= load_val;
        else if (SS) cnt <= u ? cnt + 4'd1 : cnt - 4'd1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, want, $time);
        end
    endtask

    function automatic exp_t model(input int c, input int t);
        exp_t e;
        int n;
        bit up;
`ifdef COUNTER_SEQ_WRAP_EN
        n  = (t - c + M) % M;
        up = n <= M / 2;
        if (!up) n = M - n;
`else
        up = t > c;
        n  = up ? t - c : c - t;
`endif
        e.steps  = n;
        e.ups    = up ? n : 0;
        e.cycles = 3 * n + 2;
        e.fin    = t;
        return e;
    endfunction

    // monitor: tracks each operation from busy rising and checks it against the queued expectation
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            active = 0;
            post = 0;
        end else begin
            if (post) begin
                chk("idle_after_end", 32'({busy, req_ready}), 32'd1);
                post = 0;
            end
            if (!active && busy) begin
                active = 1;
                cyc = 0;
                nss = 0;
                nup = 0;
                prev = 0;
            end
            if (active) begin
                cyc++;
                if (SS) begin
                    nss++;
                    nup += int'(u);
                    chk("ss_single_cycle", 32'(prev), 32'd0);
                end
                prev = SS;
                if (done || timeout) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_end got=done:%0b,timeout:%0b expected=no operation", done, timeout);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("end_kind", 32'({done, timeout}), 32'd2);
                        chk("done_cycle", cyc, e.cycles);
                        chk("step_pulses", nss, e.steps);
                        chk("up_pulses", nup, e.ups);
                        chk("final_cnt", 32'(cnt), e.fin);
                    end
                    active = 0;
                    post = 1;
                end else if (cyc > 120) begin
                    checks++;
                    failures++;
                    $display("FAIL op_bound got=%0d cycles expected=completion", cyc);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    active = 0;
                end
            end else begin
                chk("idle_quiet", 32'({SS, done, timeout}), 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(req_ready && !busy) && k < 400);
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL wait_idle got=busy expected=idle within 400 cycles");
        end
    endtask

    task automatic load(input logic [3:0] v);
        wait_idle();
        load_val = v;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] t, input bit spur);
        wait_idle();
        exp_q.push_back(model(int'(cnt), int'(t)));
        req_target = t;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = spur;
        req_target = ~t;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, ns, ups, tc, dn;
        exp_t e;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ss", 32'(SS), 32'd0);
        chk("rst_u", 32'(u), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // stuck counter against a 4-step limit
        t_target = 4'd8;
        t_valid = 1'b1;
        ns = 0; ups = 0; tc = -1; dn = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) t_valid = 1'b0;
            if (t_ss) begin
                ns++;
                ups += int'(t_u);
            end
            if (t_done) dn++;
            if (t_tout && tc < 0) tc = i;
        end
        chk("tout_pulses", ns, TM);
        chk("tout_up_pulses", ups, TM);
        chk("tout_cycle", tc, 3 * TM + 2);
        chk("tout_no_done", dn, 0);
        chk("tout_back_idle", 32'({t_ready, t_busy}), 32'd2);

        load(4'd2);
        issue(4'd5, 1'b0);
        load(4'd9);
        issue(4'd6, 1'b1);
        issue(4'd6, 1'b0);
        load(4'd14);
        issue(4'd1, 1'b0);

        // reset in the middle of the second step
        load(4'd0);
        wait_idle();
        e = model(0, 10);
        exp_q.push_back(e);
        req_target = 4'd10;
        req_valid = 1'b1;
        k = 0;
        ns = 0;
        while (ns < 2 && k < 50) begin
            @(negedge clk);
            req_valid = 1'b0;
            k++;
            if (SS) ns++;
        end
        if (ns < 2) begin
            checks++;
            failures++;
            $display("FAIL midop_second_step got=%0d pulses expected=2", ns);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ss", 32'(SS), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        chk("midrst_cnt_kept", 32'(cnt), e.ups > 0 ? 32'd1 : 32'd15);
        rst_n = 1'b1;
        issue(4'd7, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(1) == 1) load(4'($urandom_range(M - 1)));
            issue(4'($urandom_range(M - 1)), 1'($urandom_range(1)));
            repeat ($urandom_range(3)) @(negedge clk);
        end
        wait_idle();
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
